// File: rtl/dp_seq_pkg.sv
// dp_seq_pkg: shared state, opcode and operand-class definitions for the sequencer
package dp_seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, MEM, ARG, EXEC, LOAD, DONE} state_t;
  typedef enum logic [2:0] {C_NOP, C_MEM, C_IMM, C_LDA, C_HALT} cls_t;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_SUBI = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_LDA  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hC;
  // bit n set means opcode n belongs to the class
  localparam logic [15:0] MEM_OPS = 16'h01EA;
  localparam logic [15:0] IMM_OPS = 16'h0614;
endpackage

// File: rtl/dp_seq_dec.sv
// dp_seq_dec: opcode to class, one-hot op select (bit 0 = ADD .. bit 9 = SHR) and illegal flag
module dp_seq_dec
  import dp_seq_pkg::*;
(
  input  logic [3:0] opc,
  output cls_t       cls,
  output logic [9:0] ops,
  output logic       illegal
);
  always_comb begin
    illegal = opc > OP_HALT;
    ops     = (opc >= OP_ADD && opc <= OP_SHR) ? 10'd1 << (opc - OP_ADD) : 10'd0;
    cls     = MEM_OPS[opc] ? C_MEM :
              IMM_OPS[opc] ? C_IMM :
              opc == OP_LDA ? C_LDA :
              opc == OP_HALT ? C_HALT : C_NOP;
  end
endmodule

// File: rtl/dp_seq.sv
// dp_seq: instruction/operand fetch sequencer driving the accumulator datapath strobes
module dp_seq
  import dp_seq_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int TMO   = 15
) (
  input  logic             clka,
  input  logic             restart_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic             mem_req,
  output logic [3:0]       mem_addr,
  input  logic             mem_ack,
  output logic             load_accu,
  output logic             arith_mem,
  output logic             execute_en,
  output logic             op_add,
  output logic             op_addi,
  output logic             op_sub,
  output logic             op_subi,
  output logic             op_and,
  output logic             op_or,
  output logic             op_xor,
  output logic             op_not,
  output logic             op_shl,
  output logic             op_shr,
  output logic [3:0]       imm,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] icount,
  output logic             err_illegal,
  output logic             err_tmo
);
  localparam int TW = $clog2(TMO + 1);
  state_t           state_q, state_d;
  logic [7:0]       instr_q, instr_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic             err_ill_q, err_ill_d, err_tmo_q, err_tmo_d;
  cls_t             cls;
  logic [9:0]       ops;
  logic             illegal;
  dp_seq_dec u_dec (.opc(instr_q[7:4]), .cls(cls), .ops(ops), .illegal(illegal));
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    tmo_d     = tmo_q;
    icount_d  = icount_q;
    err_ill_d = err_ill_q;
    err_tmo_d = err_tmo_q;
    case (state_q)
      IDLE:   state_d = start ? FETCH : IDLE;
      FETCH: begin
        instr_d = instr_valid ? instr : instr_q;
        state_d = instr_valid ? DECODE : FETCH;
      end
      DECODE: begin
        tmo_d     = '0;
        err_ill_d = err_ill_q | illegal;
        state_d   = cls == C_MEM ? MEM : cls == C_IMM ? EXEC : cls == C_LDA ? LOAD :
                    cls == C_HALT ? DONE : FETCH;
        icount_d  = (cls == C_NOP || cls == C_HALT) ? icount_q + 1'b1 : icount_q;
      end
      MEM: begin
        tmo_d     = tmo_q + 1'b1;
        err_tmo_d = err_tmo_q | (!mem_ack && tmo_q == TW'(TMO - 1));
        state_d   = mem_ack ? ARG : tmo_q == TW'(TMO - 1) ? IDLE : MEM;
      end
      ARG:    state_d = EXEC;
      EXEC, LOAD: begin
        state_d  = FETCH;
        icount_d = icount_q + 1'b1;
      end
      DONE:   state_d = start ? DONE : IDLE;
    endcase
    // abort wins over everything and leaves no trace of the in-flight instruction
    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      instr_d   = instr_q;
      icount_d  = icount_q;
      err_ill_d = err_ill_q;
      err_tmo_d = err_tmo_q;
    end
  end
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      tmo_q     <= '0;
      icount_q  <= '0;
      err_ill_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      tmo_q     <= tmo_d;
      icount_q  <= icount_d;
      err_ill_q <= err_ill_d;
      err_tmo_q <= err_tmo_d;
    end
  end
  always_comb begin
    instr_ready = state_q == FETCH;
    mem_req     = state_q == MEM;
    arith_mem   = state_q == ARG;
    execute_en  = state_q == EXEC;
    load_accu   = state_q == LOAD;
    done        = state_q == DONE;
    busy        = state_q != IDLE && state_q != DONE;
    mem_addr    = instr_q[3:0];
    imm         = instr_q[3:0];
    icount      = icount_q;
    err_illegal = err_ill_q;
    err_tmo     = err_tmo_q;
    {op_shr, op_shl, op_not, op_xor, op_or, op_and, op_subi, op_sub, op_addi, op_add} =
      ops & {10{execute_en}};
  end
endmodule

// File: tb/tb_dp_seq.sv
// tb_dp_seq: directed-step bench for dp_seq with immediate-assertion checks
module tb_dp_seq;
  logic       clka = 1'b0, restart_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       instr_valid = 1'b0, mem_ack = 1'b0;
  logic       instr_ready, mem_req, load_accu, arith_mem, execute_en, busy, done;
  logic       op_add, op_addi, op_sub, op_subi, op_and, op_or, op_xor, op_not, op_shl, op_shr;
  logic [3:0] mem_addr, imm;
  logic [7:0] icount;
  logic       err_illegal, err_tmo;
  logic [9:0] ops;
  int         n_run = 0, n_fail = 0, n_req, n_exe;
  dp_seq #(.CNT_W(8), .TMO(15)) dut (
    .clka(clka), .restart_n(restart_n), .start(start), .abort(abort),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .load_accu(load_accu), .arith_mem(arith_mem), .execute_en(execute_en),
    .op_add(op_add), .op_addi(op_addi), .op_sub(op_sub), .op_subi(op_subi),
    .op_and(op_and), .op_or(op_or), .op_xor(op_xor), .op_not(op_not),
    .op_shl(op_shl), .op_shr(op_shr), .imm(imm), .busy(busy), .done(done),
    .icount(icount), .err_illegal(err_illegal), .err_tmo(err_tmo)
  );
  assign ops = {op_shr, op_shl, op_not, op_xor, op_or, op_and, op_subi, op_sub, op_addi, op_add};
  always #5 clka = ~clka;
  task automatic tick();
    @(posedge clka);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {instr_ready, mem_req, load_accu, arith_mem, execute_en, done}, 0);
    chk("rst_ops_imm", {ops, imm, mem_addr}, 0);
    chk("rst_icount", icount, 0);
    chk("rst_err", {err_illegal, err_tmo}, 0);
    #9 restart_n = 1'b1;
    tick();
    // ADDI 3
    start = 1'b1; instr = 8'h23; instr_valid = 1'b1;
    tick();
    chk("addi_ready", instr_ready, 1);
    chk("addi_busy", busy, 1);
    tick();
    instr_valid = 1'b0; start = 1'b0;
    chk("addi_decode_ready", instr_ready, 0);
    chk("addi_decode_exe", execute_en, 0);
    tick();
    chk("addi_exe", execute_en, 1);
    chk("addi_ops", ops, 10'h002);
    chk("addi_imm", imm, 3);
    chk("addi_icount_pre", icount, 0);
    tick();
    chk("addi_icount", icount, 1);
    chk("addi_back_fetch", instr_ready, 1);
    chk("addi_exe_off", {execute_en, ops}, 0);
    // ADD addr 5, ack after two wait cycles
    instr = 8'h15; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("add_decode_req", mem_req, 0);
    tick();
    chk("add_req0", {mem_req, mem_addr}, 5'h15);
    tick();
    chk("add_req1", {mem_req, mem_addr}, 5'h15);
    tick();
    chk("add_req2", {mem_req, mem_addr}, 5'h15);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("add_arg", {arith_mem, execute_en, mem_req}, 3'b100);
    tick();
    chk("add_exe", {arith_mem, execute_en}, 2'b01);
    chk("add_ops", ops, 10'h001);
    tick();
    chk("add_icount", icount, 2);
    chk("add_fetch", {instr_ready, execute_en, arith_mem}, 3'b100);
    // SUB 0x3A, no ack -> timeout
    instr = 8'h3A; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    n_req = 0; n_exe = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_req += int'(mem_req);
      n_exe += int'(execute_en | arith_mem);
    end
    chk("tmo_req_cycles", n_req, 15);
    chk("tmo_no_exe", n_exe, 0);
    chk("tmo_err", err_tmo, 1);
    chk("tmo_idle", {busy, instr_ready, done}, 0);
    chk("tmo_icount", icount, 2);
    // stream LDA, illegal, HALT
    start = 1'b1;
    tick();
    instr = 8'hB0; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("lda_load", load_accu, 1);
    tick();
    chk("lda_load_off", load_accu, 0);
    chk("lda_icount", icount, 3);
    instr = 8'hE0; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("ill_err", err_illegal, 1);
    chk("ill_fetch", {instr_ready, execute_en}, 2'b10);
    chk("ill_icount", icount, 4);
    instr = 8'hC0; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("halt_done", {done, busy}, 2'b10);
    chk("halt_icount", icount, 5);
    tick();
    chk("halt_hold", done, 1);
    start = 1'b0;
    tick();
    chk("halt_idle", {done, busy}, 0);
    chk("err_sticky", {err_illegal, err_tmo}, 2'b11);
    // abort together with mem_ack
    start = 1'b1;
    tick();
    start = 1'b0; instr = 8'h15; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("abort_in_mem", mem_req, 1);
    mem_ack = 1'b1; abort = 1'b1;
    tick();
    mem_ack = 1'b0; abort = 1'b0;
    chk("abort_idle", {busy, mem_req, arith_mem, execute_en}, 0);
    tick();
    chk("abort_quiet", {busy, arith_mem, execute_en}, 0);
    chk("abort_icount", icount, 5);
    // reset mid-EXEC
    start = 1'b1;
    tick();
    start = 1'b0; instr = 8'h23; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("rst_exec_pre", {execute_en, op_addi}, 2'b11);
    #2 restart_n = 1'b0;
    #1;
    chk("rst_async_out", {execute_en, ops, busy, imm, mem_addr}, 0);
    chk("rst_async_cnt", icount, 0);
    chk("rst_async_err", {err_illegal, err_tmo}, 0);
    #2 restart_n = 1'b1;
    tick();
    chk("rst_after_idle", {busy, instr_ready, done}, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/dp_seq.md
Name: dp_seq

Overview:
- Sequencer for the 8-bit accumulator datapath: fetches 8-bit instructions over a valid/ready stream, decodes them, and fetches memory operands over a req/ack port.
- Drives the datapath strobes (load_accu, arith_mem, execute_en, one-hot op select, imm) one cycle at a time.
- Sits between instruction/data memory and the datapath; reports done, an instruction count, and error flags.

Parameters:
- CNT_W, 8: width of the retired-instruction counter.
- TMO, 15: maximum number of cycles spent waiting on mem_ack before a timeout error is raised.

Ports:
- clka  in  1  single system clock, rising edge.
- restart_n  in  1  asynchronous active-low reset.
- start  in  1  level; leaves IDLE when high.
- abort  in  1  synchronous abort; returns to IDLE.
- instr  in  8  instruction: opcode [7:4], imm [3:0].
- instr_valid  in  1  instruction word present.
- instr_ready  out  1  sequencer accepts the instruction.
- mem_req  out  1  operand read request.
- mem_addr  out  4  operand address, equal to the captured imm.
- mem_ack  in  1  operand valid on the datapath reg_in this cycle.
- load_accu, arith_mem, execute_en  out  1 each  datapath strobes.
- op_add, op_addi, op_sub, op_subi, op_and, op_or, op_xor, op_not, op_shl, op_shr  out  1 each  one-hot op select.
- imm  out  4  captured immediate.
- busy  out  1  high in any state except IDLE and DONE.
- done  out  1  high in DONE.
- icount  out  CNT_W  retired instructions.
- err_illegal  out  1  sticky; illegal opcode seen.
- err_tmo  out  1  sticky; memory timeout.

Behaviour:
- All flops reset asynchronously on restart_n low.
- On reset: state=IDLE; every output is 0; icount=0; captured instr=0.
- Outputs are Moore outputs decoded from the state and captured-opcode registers. At most one op_* is high, and only while execute_en is high.
- Opcode map:
  - 0 NOP, 1 ADD, 2 ADDI, 3 SUB, 4 SUBI, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 SHL, A SHR, B LDA, C HALT.
  - D-F are illegal: set err_illegal and are treated as NOP.
  - Memory-operand ops: 1, 3, 5, 6, 7, 8. Immediate ops: 2, 4, 9, A.
- States:
  - IDLE: all strobes low. start=1 -> FETCH.
  - FETCH: instr_ready=1. On instr_valid, capture instr -> DECODE. Otherwise hold.
  - DECODE: 1 cycle. Memory op -> MEM. Immediate op -> EXEC. LDA -> LOAD. NOP or illegal -> FETCH, icount+1. HALT -> DONE, icount+1.
  - MEM: mem_req=1, mem_addr=imm. Timeout counter starts at 0 and increments each cycle.
    - On mem_ack -> ARG.
    - If the counter reaches TMO without ack: set err_tmo -> IDLE. The instruction is not retired.
  - ARG: arith_mem=1 for 1 cycle -> EXEC.
  - EXEC: execute_en=1 plus the selected op_* for exactly 1 cycle -> FETCH, icount+1.
  - LOAD: load_accu=1 for 1 cycle -> FETCH, icount+1.
  - DONE: done=1. Stays until start=0, then -> IDLE.
- Cycle counts, FETCH accept cycle included:
  - Immediate op: 3 cycles.
  - Memory op with ack in the first MEM cycle: 5 cycles.
  - LDA: 3 cycles.
  - NOP: 2 cycles.
- arith_mem and execute_en are never high in the same cycle, so the datapath has latched reg_in before execution.
- abort (sampled at a rising edge, any state except IDLE):
  - Next state is IDLE; no strobe in the following cycle.
  - Takes priority over every other transition, including mem_ack and instr_valid in the same cycle.
  - An instruction aborted mid-flight is not counted.
- start is ignored outside IDLE and DONE.
- icount wraps from 2^CNT_W-1 to 0 with no flag.
- err_* flags clear only on reset.
- instr_valid while not in FETCH is ignored: no capture, and instr_ready stays low.

Decomposition:
- Package dp_seq_pkg holds:
  - state enum: IDLE, FETCH, DECODE, MEM, ARG, EXEC, LOAD, DONE;
  - opcode constants 0x0-0xC;
  - the is_mem_op and is_imm_op classification constants.
- One sub-module, dp_seq_dec: combinational opcode -> {class, one-hot op vector, illegal}. The FSM and counters stay in dp_seq.

Test Plan:
- Reset mid-EXEC: drop restart_n asynchronously -> all outputs 0 immediately; state IDLE; icount=0.
- ADDI 3 (0x23), start=1, instr_valid held -> instr_ready 1 cycle, then execute_en+op_addi in cycle 3 with imm=3; icount=1; next cycle is FETCH.
- ADD addr 5 (0x15), mem_ack after 2 wait cycles -> mem_req high 3 cycles with mem_addr=5; arith_mem 1 cycle; execute_en+op_add the next cycle; no overlap of arith_mem and execute_en.
- SUB 0x3A with mem_ack never asserted -> mem_req high for TMO cycles; err_tmo=1; back to IDLE; icount unchanged; no execute_en.
- Stream 0xB0, 0xE0, 0xC0 -> load_accu 1 cycle; err_illegal=1; done=1; icount=3. start=0 -> IDLE, done=0.
- abort asserted in the same cycle as mem_ack -> IDLE next cycle; arith_mem and execute_en never assert; icount unchanged.
